shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for the CPU-16 shift datapath.
- Accepts one shift command (SLL, SRL, SRA or ROL) with a 16-bit operand and a 4-bit shift amount.
- Steps a 1-bit shift register once per clock until the amount is exhausted, then returns the result with a one-cycle done pulse.
- Sits between the decode/execute control and the register-file writeback. It replaces a full barrel shifter on area-constrained builds.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SHW, 4, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe; sampled only when busy=0.
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- A  input  WIDTH  operand.
- shiftAmount  input  SHW  shift count, 0..15.
- abort  input  1  synchronous cancel of the current operation.
- busy  output  1  high while a command is executing.
- done  output  1  one-cycle pulse; result valid.
- out  output  WIDTH  result register; holds until the next accepted start.
- carry  output  1  last bit shifted out; 0 when shiftAmount=0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, out=0, carry=0.
  - Internal count=0.
- States: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1 (busy=0), the command is accepted on that edge:
  - Latch op.
  - Load the shift register with A.
  - count=shiftAmount.
  - carry=0.
  - Next state is SHIFT if shiftAmount≠0, otherwise DONE.
- DONE with start=0: next state is IDLE.
- SHIFT, one bit per cycle:
  - SLL: reg<={reg[14:0],0}, carry<=reg[15].
  - SRL: reg<={0,reg[15:1]}, carry<=reg[0].
  - SRA: reg<={reg[15],reg[15:1]}, carry<=reg[0].
  - ROL: reg<={reg[14:0],reg[15]}, carry<=reg[15].
  - count decrements each cycle. When count==1 before the decrement (the last shift), next state is DONE.
- Outputs by state:
  - busy=1 exactly in SHIFT.
  - done=1 exactly in DONE.
  - out mirrors the shift register and is only guaranteed valid when done=1 or in IDLE after done.
- Latency: done asserts shiftAmount+1 cycles after the accepting edge (shamt=0 gives 1 cycle; shamt=15 gives 16 cycles).
- start while busy=1 is ignored: no queueing, no error.
- Back-to-back: start during the DONE cycle is accepted. The next command begins without an IDLE bubble, and done still pulses for the first command.
- abort=1 in SHIFT:
  - Next state is IDLE, no done pulse.
  - out/carry hold their partial values and are invalid.
- abort in IDLE or DONE has no effect. abort has priority over start in the same cycle.
- Inputs A, op and shiftAmount are don't-care after the accepting edge; changing them mid-operation must not affect the result.
- Reset mid-operation: immediate return to the reset values; no done pulse.
- All arithmetic is modulo 2^WIDTH. SRA with shamt=15 yields all sign bits.

Test Plan:
- SLL, A=16'd4, shiftAmount=2, start 1 cycle -> busy high 2 cycles; done pulses on the 3rd edge; out=16'd16, carry=0.
- SRA, A=16'h8000, shiftAmount=15 -> done after 16 cycles; out=16'hFFFF, carry=0. Same command with op=SRL -> out=16'h0001, carry=0.
- ROL, A=16'h8001, shiftAmount=1 -> done after 2 cycles; out=16'h0003, carry=1. shiftAmount=0 with A=16'h1234 -> done after 1 cycle, busy never high; out=16'h1234, carry=0.
- During an SLL of A=16'h00FF by 8, assert start with A=16'hFFFF every busy cycle -> ignored; out=16'hFF00, carry=0. A second start in the DONE cycle (SRL, 16'hFF00 by 4) -> out=16'h0FF0 after 5 more cycles.
- abort on the 3rd SHIFT cycle of an 8-bit shift -> state returns to IDLE next edge; no done pulse; busy=0; a new command then runs normally.
- rst_n pulsed low mid-SHIFT (asynchronously, between edges) -> busy, done, out and carry go to 0 immediately; a command after release completes correctly.

Source files
------------

// File: rtl/shift_seq_ctrl_if.sv
// Command/result bundle between execute control and the serial shift sequencer.
// Signal suffixes are named from the sequencer's side of the link.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [SHW-1:0]   shift_amount_i;
    logic             abort_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] out_o;
    logic             carry_o;

    modport master (
        output start_i, op_i, a_i, shift_amount_i, abort_i,
        input  busy_o, done_o, out_o, carry_o
    );

    modport slave (
        input  start_i, op_i, a_i, shift_amount_i, abort_i,
        output busy_o, done_o, out_o, carry_o
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Serial shift sequencer: one bit position per clock, a stand-in for a barrel
// shifter on small builds. Result and last shifted-out bit are held until the next accepted start.
//
// state   | meaning
// S_IDLE  | waiting for start; out/carry hold the previous result
// S_SHIFT | stepping the shift register, busy high
// S_DONE  | one-cycle done pulse; a new start is accepted here too
module shift_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
    typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROL} op_e;

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] sreg_q;
    logic [SHW-1:0]   count_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] shift_d;
    logic             carry_d;

    always_comb begin
        shift_d = sreg_q;
        carry_d = carry_q;
        case (op_q)
            OP_SLL: begin
                shift_d = {sreg_q[WIDTH-2:0], 1'b0};
                carry_d = sreg_q[WIDTH-1];
            end
            OP_SRL: begin
                shift_d = {1'b0, sreg_q[WIDTH-1:1]};
                carry_d = sreg_q[0];
            end
            OP_SRA: begin
                shift_d = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
                carry_d = sreg_q[0];
            end
            OP_ROL: begin
                shift_d = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
                carry_d = sreg_q[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_SLL;
            sreg_q  <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    // abort outranks the last shift; partial out/carry are left as-is
                    if (bus.abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        sreg_q  <= shift_d;
                        carry_q <= carry_d;
                        count_q <= count_q - SHW'(1);
                        if (count_q == SHW'(1)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.start_i) begin
                        op_q    <= op_e'(bus.op_i);
                        sreg_q  <= bus.a_i;
                        count_q <= bus.shift_amount_i;
                        carry_q <= 1'b0;
                        if (bus.shift_amount_i != '0) begin
                            state_q <= S_SHIFT;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.out_o   = sreg_q;
    assign bus.carry_o = carry_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed cases with literal results, then random
// traffic, all watched every cycle by an arithmetic reference model.
module tb_shift_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    shift_seq_ctrl_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    shift_seq_ctrl #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-operation result from plain arithmetic: {carry, result}
    function automatic logic [WIDTH:0] ref_shift(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                                 input int n);
        logic [WIDTH-1:0] r;
        logic             c;
        if (n == 0) return {1'b0, a};
        case (op)
            2'd0: begin r = a << n;                          c = a[WIDTH-n]; end
            2'd1: begin r = a >> n;                          c = a[n-1];     end
            2'd2: begin r = WIDTH'($signed(a) >>> n);        c = a[n-1];     end
            default: begin r = (a << n) | (a >> (WIDTH-n));  c = a[WIDTH-n]; end
        endcase
        return {c, r};
    endfunction

    // Reference: a command occupies shamt busy cycles, then one done cycle
    bit               m_busy, m_done, m_valid, m_carry;
    int               m_rem;
    logic [WIDTH-1:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_rem = 0; m_res = '0; m_carry = 0; m_valid = 1;
        end else if (m_busy) begin
            m_done = 0;
            if (bus.abort_i) begin
                m_busy = 0; m_valid = 0;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0; m_done = 1; m_valid = 1;
                end
            end
        end else if (bus.start_i) begin
            {m_carry, m_res} = ref_shift(bus.op_i, bus.a_i, int'(bus.shift_amount_i));
            m_rem   = int'(bus.shift_amount_i);
            m_done  = (m_rem == 0);
            m_busy  = (m_rem != 0);
            m_valid = (m_rem == 0);
        end else begin
            m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("model busy", 32'(bus.busy_o), 32'(m_busy));
            check("model done", 32'(bus.done_o), 32'(m_done));
            if (m_valid) begin
                check("model out", 32'(bus.out_o), 32'(m_res));
                check("model carry", 32'(bus.carry_o), 32'(m_carry));
            end
        end
    end

    // Called at a falling edge; leaves the bench in the done cycle
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [15:0] a,
                           input logic [3:0] sh, input logic [15:0] eo, input logic ec);
        int lat;
        bit seen_busy;
        bus.start_i = 1'b1; bus.op_i = op; bus.a_i = a; bus.shift_amount_i = sh;
        lat = 0; seen_busy = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.start_i = 1'b0;
            if (bus.busy_o) seen_busy = 1;
        end while (!bus.done_o && lat < 40);
        check({name, " latency"}, 32'(lat), 32'(int'(sh) + 1));
        check({name, " out"}, 32'(bus.out_o), 32'(eo));
        check({name, " carry"}, 32'(bus.carry_o), 32'(ec));
        if (sh == 4'd0) check({name, " busy seen"}, 32'(seen_busy), 32'd0);
    endtask

    initial begin
        int lat;
        n_cmp = 0; n_err = 0;
        bus.start_i = 0; bus.op_i = 0; bus.a_i = '0; bus.shift_amount_i = '0; bus.abort_i = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset done", 32'(bus.done_o), 32'd0);
        check("reset out", 32'(bus.out_o), 32'd0);
        check("reset carry", 32'(bus.carry_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd("sll4x2", 2'd0, 16'd4, 4'd2, 16'd16, 1'b0);
        run_cmd("sra8000x15", 2'd2, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
        run_cmd("srl8000x15", 2'd1, 16'h8000, 4'd15, 16'h0001, 1'b0);
        run_cmd("rol8001x1", 2'd3, 16'h8001, 4'd1, 16'h0003, 1'b1);
        run_cmd("shamt0", 2'd0, 16'h1234, 4'd0, 16'h1234, 1'b0);
        @(negedge clk);

        // Starts held high through the whole shift must be ignored
        bus.start_i = 1'b1; bus.op_i = 2'd0; bus.a_i = 16'h00FF; bus.shift_amount_i = 4'd8;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.a_i = 16'hFFFF;
        end while (!bus.done_o && lat < 40);
        check("ignored latency", 32'(lat), 32'd9);
        check("ignored out", 32'(bus.out_o), 32'h0000_FF00);
        check("ignored carry", 32'(bus.carry_o), 32'd0);
        run_cmd("b2b srl", 2'd1, 16'hFF00, 4'd4, 16'h0FF0, 1'b0);
        @(negedge clk);

        bus.start_i = 1'b1; bus.op_i = 2'd0; bus.a_i = 16'h1357; bus.shift_amount_i = 4'd8;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        check("abort busy", 32'(bus.busy_o), 32'd0);
        check("abort done", 32'(bus.done_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort no done", 32'(bus.done_o), 32'd0);
        end
        run_cmd("after abort", 2'd2, 16'hF0F0, 4'd3, 16'hFE1E, 1'b0);
        @(negedge clk);

        bus.start_i = 1'b1; bus.op_i = 2'd2; bus.a_i = 16'h8421; bus.shift_amount_i = 4'd10;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", 32'(bus.busy_o), 32'd0);
        check("async rst done", 32'(bus.done_o), 32'd0);
        check("async rst out", 32'(bus.out_o), 32'd0);
        check("async rst carry", 32'(bus.carry_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd("after reset", 2'd3, 16'h1234, 4'd4, 16'h2341, 1'b1);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus.start_i        = ($urandom_range(0, 2) == 0);
            bus.op_i           = 2'($urandom_range(0, 3));
            bus.a_i            = 16'($urandom);
            bus.shift_amount_i = 4'($urandom_range(0, 15));
            bus.abort_i        = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        bus.start_i = 1'b0; bus.abort_i = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
